// File: rtl/confrontatore_pkg.sv
// Shared types and helpers for the sequential chunked comparator.
package confrontatore_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } state_e;

  // Chunk index counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/confrontatore_chunk.sv
// Combinational K-bit chunk compare: inequality, plus unsigned less-than
// when CONFRONTATORE_SEQ_MAG_EN is defined.
module confrontatore_chunk #(
  parameter int unsigned K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
`ifdef CONFRONTATORE_SEQ_MAG_EN
  output logic         lt,
`endif
  output logic         ne
);

  assign ne = (a != b);
`ifdef CONFRONTATORE_SEQ_MAG_EN
  assign lt = (a < b);
`endif

endmodule

// File: rtl/confrontatore_seq.sv
// Multi-cycle N-bit comparator, MS chunk first with early exit on the first
// differing chunk. Magnitude (minore) output enabled by CONFRONTATORE_SEQ_MAG_EN.
module confrontatore_seq
  import confrontatore_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned K = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef CONFRONTATORE_SEQ_MAG_EN
  output logic         minore,
`endif
  output logic         diverso
);

  localparam int unsigned CHUNKS = N / K;
  localparam int unsigned IdxW   = cnt_width(CHUNKS);

  if ((K == 0) || (N % K != 0)) begin : g_bad_k
    $error("confrontatore_seq: N must be a non-zero multiple of K");
  end

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             diverso_q, diverso_d;
  logic [K-1:0]     chunk_a, chunk_b;
  logic             chunk_ne;
`ifdef CONFRONTATORE_SEQ_MAG_EN
  logic             minore_q, minore_d;
  logic             chunk_lt;
`endif

  assign chunk_a = a_q[idx_q*K +: K];
  assign chunk_b = b_q[idx_q*K +: K];

  confrontatore_chunk #(
    .K (K)
  ) u_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
`ifdef CONFRONTATORE_SEQ_MAG_EN
    .lt (chunk_lt),
`endif
    .ne (chunk_ne)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    diverso_d   = diverso_q;
`ifdef CONFRONTATORE_SEQ_MAG_EN
    minore_d    = minore_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = x1;
          b_d     = x2;
          idx_d   = IdxW'(CHUNKS - 1);
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (chunk_ne) begin
          diverso_d   = 1'b1;
`ifdef CONFRONTATORE_SEQ_MAG_EN
          minore_d    = chunk_lt;
`endif
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else if (idx_q == '0) begin
          diverso_d   = 1'b0;
`ifdef CONFRONTATORE_SEQ_MAG_EN
          minore_d    = 1'b0;
`endif
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand registers are not cleared: they are only read after an accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      diverso_q   <= 1'b0;
`ifdef CONFRONTATORE_SEQ_MAG_EN
      minore_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      diverso_q   <= diverso_d;
`ifdef CONFRONTATORE_SEQ_MAG_EN
      minore_q    <= minore_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = out_valid_q;
  assign diverso   = diverso_q;
`ifdef CONFRONTATORE_SEQ_MAG_EN
  assign minore    = minore_q;
`endif

endmodule

// File: tb/tb_confrontatore_seq.sv
// Directed bench for confrontatore_seq: N=16/K=4 instance plus a K=N=16 instance.
// Minore is checked only when CONFRONTATORE_SEQ_MAG_EN is defined.
module tb_confrontatore_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, diverso;
  logic [15:0] x1, x2;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, diverso1;
  logic [15:0] x1_1, x2_1;
`ifdef CONFRONTATORE_SEQ_MAG_EN
  logic        minore, minore1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  confrontatore_seq #(
    .N (16),
    .K (4)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CONFRONTATORE_SEQ_MAG_EN
    .minore    (minore),
`endif
    .diverso   (diverso)
  );

  confrontatore_seq #(
    .N (16),
    .K (16)
  ) u_dut1 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .x1        (x1_1),
    .x2        (x2_1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
`ifdef CONFRONTATORE_SEQ_MAG_EN
    .minore    (minore1),
`endif
    .diverso   (diverso1)
  );

  // Drives one transfer into u_dut and measures edges from accept to out_valid.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic dv, output logic mn);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) break;
      @(posedge clock); #1;
      if (out_valid) lat = i;
    end
    dv = diverso;
`ifdef CONFRONTATORE_SEQ_MAG_EN
    mn = minore;
`else
    mn = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b0;
    out_ready1 = 1'b1;
    x1 = '0; x2 = '0; x1_1 = '0; x2_1 = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid cyc %0d got %b want 0", c, out_valid);
      end
      checks++;
      if (diverso !== 1'b0) begin
        errors++; $display("FAIL reset_diverso cyc %0d got %b want 0", c, diverso);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL reset_in_ready cyc %0d got %b want 0", c, in_ready);
      end
`ifdef CONFRONTATORE_SEQ_MAG_EN
      checks++;
      if (minore !== 1'b0) begin
        errors++; $display("FAIL reset_minore cyc %0d got %b want 0", c, minore);
      end
`endif
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready1 got %b want 1", in_ready1);
    end
  endtask

  task automatic check_back_to_idle(input string name);
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_idle_out_valid got %b want 0", name, out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_idle_in_ready got %b want 1", name, in_ready);
    end
  endtask

  task automatic test_equal();
    int lat; logic dv, mn;
    out_ready = 1'b1;
    run_cmp(16'hBEEF, 16'hBEEF, lat, dv, mn);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL equal_latency got %0d want 4", lat); end
    checks++;
    if (dv !== 1'b0) begin errors++; $display("FAIL equal_diverso got %b want 0", dv); end
`ifdef CONFRONTATORE_SEQ_MAG_EN
    checks++;
    if (mn !== 1'b0) begin errors++; $display("FAIL equal_minore got %b want 0", mn); end
`endif
    check_back_to_idle("equal");
  endtask

  task automatic test_first_chunk();
    int lat; logic dv, mn;
    out_ready = 1'b1;
    run_cmp(16'h1234, 16'h9234, lat, dv, mn);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL msc_lt_latency got %0d want 1", lat); end
    checks++;
    if (dv !== 1'b1) begin errors++; $display("FAIL msc_lt_diverso got %b want 1", dv); end
`ifdef CONFRONTATORE_SEQ_MAG_EN
    checks++;
    if (mn !== 1'b1) begin errors++; $display("FAIL msc_lt_minore got %b want 1", mn); end
`endif
    check_back_to_idle("msc_lt");
    run_cmp(16'h9234, 16'h1234, lat, dv, mn);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL msc_gt_latency got %0d want 1", lat); end
    checks++;
    if (dv !== 1'b1) begin errors++; $display("FAIL msc_gt_diverso got %b want 1", dv); end
`ifdef CONFRONTATORE_SEQ_MAG_EN
    checks++;
    if (mn !== 1'b0) begin errors++; $display("FAIL msc_gt_minore got %b want 0", mn); end
`endif
    check_back_to_idle("msc_gt");
  endtask

  task automatic test_hold();
    int lat; logic dv, mn;
    out_ready = 1'b0;
    run_cmp(16'hABC0, 16'hABC1, lat, dv, mn);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL hold_latency got %0d want 4", lat); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL hold_out_valid cyc %0d got %b want 1", c, out_valid);
      end
      checks++;
      if (diverso !== 1'b1) begin
        errors++; $display("FAIL hold_diverso cyc %0d got %b want 1", c, diverso);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready cyc %0d got %b want 0", c, in_ready);
      end
`ifdef CONFRONTATORE_SEQ_MAG_EN
      checks++;
      if (minore !== 1'b1) begin
        errors++; $display("FAIL hold_minore cyc %0d got %b want 1", c, minore);
      end
`endif
    end
    out_ready = 1'b1;
    check_back_to_idle("hold");
    checks++;
    if (diverso !== 1'b1) begin
      errors++; $display("FAIL hold_diverso_kept got %b want 1", diverso);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic dv, mn;
    out_ready = 1'b1;
    x1 = 16'hBEEF;
    x2 = 16'hBEEF;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_ready_in_reset got %b want 0", in_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_out_valid got %b want 0", out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_in_ready_after got %b want 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_result cyc %0d got %b want 0", c, out_valid);
      end
    end
    run_cmp(16'h0001, 16'h0000, lat, dv, mn);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL abort_next_latency got %0d want 4", lat); end
    checks++;
    if (dv !== 1'b1) begin errors++; $display("FAIL abort_next_diverso got %b want 1", dv); end
`ifdef CONFRONTATORE_SEQ_MAG_EN
    checks++;
    if (mn !== 1'b0) begin errors++; $display("FAIL abort_next_minore got %b want 0", mn); end
`endif
    check_back_to_idle("abort_next");
  endtask

  task automatic test_single_chunk();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        exp_dv [3];
    logic        exp_mn [3];
    int lat;
    va[0] = 16'hFFFF; vb[0] = 16'h0000; exp_dv[0] = 1'b1; exp_mn[0] = 1'b0;
    va[1] = 16'h0000; vb[1] = 16'hFFFF; exp_dv[1] = 1'b1; exp_mn[1] = 1'b1;
    va[2] = 16'hAAAA; vb[2] = 16'hAAAA; exp_dv[2] = 1'b0; exp_mn[2] = 1'b0;
    out_ready1 = 1'b1;
    for (int v = 0; v < 3; v++) begin
      x1_1 = va[v];
      x2_1 = vb[v];
      in_valid1 = 1'b1;
      @(posedge clock); #1;
      in_valid1 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clock); #1;
        if (out_valid1) begin lat = i; break; end
      end
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL k16_latency vec %0d got %0d want 1", v, lat);
      end
      checks++;
      if (diverso1 !== exp_dv[v]) begin
        errors++; $display("FAIL k16_diverso vec %0d got %b want %b", v, diverso1, exp_dv[v]);
      end
`ifdef CONFRONTATORE_SEQ_MAG_EN
      checks++;
      if (minore1 !== exp_mn[v]) begin
        errors++; $display("FAIL k16_minore vec %0d got %b want %b", v, minore1, exp_mn[v]);
      end
`endif
      @(posedge clock); #1;
      checks++;
      if (in_ready1 !== 1'b1) begin
        errors++; $display("FAIL k16_idle_in_ready vec %0d got %b want 1", v, in_ready1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_equal();
    test_first_chunk();
    test_hold();
    test_reset_abort();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/confrontatore_seq.md
# confrontatore_seq

Multi-cycle N-bit comparator with a valid/ready handshake on both sides and early termination on the first differing chunk. Operands are scanned most-significant chunk first, K bits per cycle. The block reports inequality with the same polarity as the existing combinational comparator: 0 when equal, 1 when different. When configured for it, it also reports unsigned magnitude order. It sits between the stack unit's operand registers and its control logic, where a full-width combinational compare is too slow for the target clock.

## Interface
Parameters:
- N, 16, operand width in bits; N >= 1.
- K, 4, chunk width compared per cycle; N % K == 0 is required (elaboration error otherwise).
- CHUNKS, N/K, derived and not overridable; counter width is max(1, $clog2(CHUNKS)).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands x1/x2 are valid.
- in_ready  out  1  block can accept operands; high only in IDLE and low while reset is high.
- x1  in  N  first operand.
- x2  in  N  second operand.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- diverso  out  1  0 if x1 == x2, else 1.
- minore  out  1  1 if x1 < x2 (unsigned); only present with magnitude support compiled in.

## Operation
- States: IDLE, CMP, DONE.
- IDLE: in_ready = 1. A transfer (in_valid && in_ready) latches x1/x2 into internal registers, sets idx = CHUNKS-1 and moves to CMP. Inputs are not sampled afterwards.
- CMP: compares latched chunk [idx*K +: K].
  - If the chunks differ: diverso <= 1; minore <= (chunk1 < chunk2); go to DONE.
  - Otherwise, if idx == 0: diverso <= 0; minore <= 0; go to DONE.
  - Otherwise: idx <= idx-1; stay in CMP.
- DONE: out_valid = 1 and diverso/minore held stable. On out_ready go to IDLE. No new operand is accepted in the same cycle; back-to-back throughput has a 1-cycle IDLE gap.
- K == N (CHUNKS = 1): every comparison completes in exactly one CMP cycle.
- out_valid/diverso/minore are registered outputs. diverso/minore keep the last result after leaving DONE and are meaningful only while out_valid = 1.

## Timing
- Reset values: state IDLE, out_valid 0, diverso 0, minore 0, idx 0, in_ready 0 during reset and 1 in the first cycle after reset deasserts.
- Reset mid-operation (CMP or DONE) aborts immediately. The result is discarded and out_valid drops on the next edge.
- Latency counts from the accept edge to out_valid high. It is j+1 cycles, where j is the number of leading equal chunks (0 <= j < CHUNKS). For equal operands it is CHUNKS cycles.
- Minimum cycle from accept to next accept: latency + 1 (DONE with out_ready = 1) + 1 (IDLE).
- in_valid with in_ready = 0 is ignored; producers hold their data until a transfer occurs.

## Configuration
- CONFRONTATORE_SEQ_MAG_EN defined:
  - The minore port and its register exist.
  - The chunk sub-module computes less-than.
- Not defined:
  - The minore port is absent and only equality is computed.
  - FSM, latency and early termination are identical in both builds.

## Structure
- Package confrontatore_pkg:
  - State enum (IDLE, CMP, DONE).
  - Function computing counter width.
- Sub-module confrontatore_chunk, purely combinational K-bit unit:
  - Outputs ne (not equal) and, under CONFRONTATORE_SEQ_MAG_EN, lt.
  - Instantiated once and fed by the idx-selected slice.
- Top level holds the operand registers, idx counter, FSM and result registers.

## Test plan
- Reset held 3 cycles, then released → out_valid=0, diverso=0, minore=0 throughout; in_ready=1 on the first post-reset cycle.
- N=16, K=4, x1=x2=16'hBEEF, out_ready=1 → out_valid high 4 cycles after accept, diverso=0, minore=0.
- x1=16'h1234, x2=16'h9234 → out_valid after 1 cycle, diverso=1, minore=1; with x1/x2 swapped → diverso=1, minore=0.
- x1=16'hABC0, x2=16'hABC1 with out_ready=0 for 5 cycles → result after 4 cycles; diverso=1 and minore=1 held stable until out_ready; in_ready=0 while waiting.
- Reset asserted in the 2nd CMP cycle of an equal-operand compare → no out_valid; IDLE and in_ready=1 after release; a following compare of 16'h0001 vs 16'h0000 gives diverso=1, minore=0 after 4 cycles.
- K=N=16 build: 16'hFFFF vs 16'h0000 → 1-cycle latency, diverso=1; build without CONFRONTATORE_SEQ_MAG_EN → same diverso and latency, and no minore port.
